// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Purpose:
//   Issues one round index per cycle to the iterative cipher datapath and key
//   schedule, plus a single completion pulse per block.
//   - The round count and the indexing direction are latched when a block
//     starts.
//   - Ascending indexing (dir=0) is used for encrypt and descending indexing
//     (dir=1) for decrypt, so both modes share one key-schedule port.
//   - Supports stall (hold the current round) and abort (terminate the block
//     cleanly).
//   - Every output is driven straight from a flop.
//
// Parameters:
//   CNT_W      - width of round index and round-count input (2^CNT_W > MAX_ROUNDS)
//   MAX_ROUNDS - largest legal round count
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   block start request (sampled only when idle)
//   rounds    in   round count for the block (latched on accepted start)
//   dir       in   0 = ascending, 1 = descending (latched on accepted start)
//   stall     in   hold current round
//   abort     in   terminate running block
//   busy      out  block in progress
//   round_vld out  round_idx valid
//   round_idx out  current round index
//   first     out  current round is the first of the block
//   last      out  current round is the last of the block
//   done      out  1-cycle pulse, block completed normally
//   aborted   out  1-cycle pulse, block terminated by abort
//   cfg_err   out  1-cycle pulse, start rejected (rounds==0 or > MAX_ROUNDS)
// -----------------------------------------------------------------------------
module round_sequencer #(
  parameter int CNT_W      = 5,
  parameter int MAX_ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rounds,
  input  logic             dir,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             round_vld,
  output logic [CNT_W-1:0] round_idx,
  output logic             first,
  output logic             last,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rounds_q, rounds_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             round_vld_q, round_vld_d;
  logic [CNT_W-1:0] round_idx_q, round_idx_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             cfg_err_q, cfg_err_d;

  // Index of the following round; only consumed on a non-last fire, where the
  // legal-range check guarantees it cannot wrap.
  logic [CNT_W-1:0] step_idx;

  always_comb begin
    state_d     = state_q;
    rounds_d    = rounds_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    round_vld_d = round_vld_q;
    round_idx_d = round_idx_q;
    first_d     = first_q;
    last_d      = last_q;
    // Status pulses are one cycle wide unless re-asserted below.
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cfg_err_d   = 1'b0;

    step_idx    = dir_q ? (round_idx_q - ONE) : (round_idx_q + ONE);

    if (state_q == IDLE) begin
      if (start) begin
        if ((rounds == '0) || (rounds > MAX_R)) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d     = RUN;
          rounds_d    = rounds;
          dir_d       = dir;
          busy_d      = 1'b1;
          round_vld_d = 1'b1;
          round_idx_d = dir ? (rounds - ONE) : '0;
          first_d     = 1'b1;
          last_d      = (rounds == ONE);
        end
      end
    end else begin
      // Abort wins over both stall and a last-round fire.
      if (abort) begin
        state_d     = IDLE;
        aborted_d   = 1'b1;
        busy_d      = 1'b0;
        round_vld_d = 1'b0;
        round_idx_d = '0;
        first_d     = 1'b0;
        last_d      = 1'b0;
      end else if (!stall) begin
        if (last_q) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          round_vld_d = 1'b0;
          round_idx_d = '0;
          first_d     = 1'b0;
          last_d      = 1'b0;
        end else begin
          round_idx_d = step_idx;
          first_d     = 1'b0;
          last_d      = dir_q ? (step_idx == '0) : (step_idx == (rounds_q - ONE));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rounds_q    <= '0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      round_vld_q <= 1'b0;
      round_idx_q <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      round_vld_q <= round_vld_d;
      round_idx_q <= round_idx_d;
      first_q     <= first_d;
      last_q      <= last_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign busy      = busy_q;
  assign round_vld = round_vld_q;
  assign round_idx = round_idx_q;
  assign first     = first_q;
  assign last      = last_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Parametrised round sequencer for the iterative cipher datapath. It generalises the fixed 17-cycle round counter with the following features:
- programmable round count, latched per block;
- up or down round indexing, so encrypt and decrypt share one key-schedule port;
- a stall input;
- a clean abort.

It sits between the bus-side control registers and the round datapath/key schedule, and issues one round index per cycle plus a single block-complete pulse.

## Interface
- `CNT_W`, default 5: width of the round index and of the round-count input. Must satisfy 2^CNT_W > MAX_ROUNDS.
- `MAX_ROUNDS`, default 16: largest legal round count.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: block start request; sampled only in IDLE.
- `rounds` in CNT_W: number of rounds for the block; latched when start is accepted.
- `dir` in 1: indexing direction, 0 = ascending (encrypt), 1 = descending (decrypt); latched when start is accepted.
- `stall` in 1: holds the current round; no advance while high.
- `abort` in 1: terminates the running block.
- `busy` out 1: block in progress.
- `round_vld` out 1: round_idx is valid.
- `round_idx` out CNT_W: current round index.
- `first` out 1: current round is the block's first round.
- `last` out 1: current round is the block's final round.
- `done` out 1: one-cycle pulse, block completed normally.
- `aborted` out 1: one-cycle pulse, block terminated by abort.
- `cfg_err` out 1: one-cycle pulse, start was rejected for an illegal rounds value.

## Operation
- States are IDLE and RUN. All outputs are registered.
- **Reset** (rst_n low at a clock edge):
  - state goes to IDLE;
  - busy, round_vld, first, last, done, aborted, cfg_err go to 0;
  - round_idx and the latched rounds/dir registers go to 0.
  - Reset takes precedence over every other input, including mid-block.
- **IDLE, start=1:**
  - If rounds==0 or rounds>MAX_ROUNDS: pulse cfg_err for one cycle and stay in IDLE.
  - Otherwise latch rounds and dir and go to RUN. round_idx loads 0 if dir=0, or rounds-1 if dir=1. busy, round_vld and first go to 1. last goes to 1 only if rounds==1.
- **IDLE, start=0:** hold. abort and stall are ignored.
- **RUN:** a round "fires" in each cycle where stall=0 and abort=0.
  - Fire on a non-last round: round_idx steps +1 if dir=0 or -1 if dir=1; first clears; last sets when the new index is the final index (rounds-1 ascending, 0 descending).
  - Fire on the last round: go to IDLE. Next cycle: done=1, busy=0, round_vld=0, first=0, last=0, round_idx=0.
  - stall=1 with abort=0: all state and outputs hold.
  - abort=1: has priority over stall and over a last-round fire. Go to IDLE. Next cycle: aborted=1, done=0, and the other outputs take their IDLE values.
  - start is ignored in RUN. The rounds and dir inputs are don't-care after they are latched.
- **Back-to-back blocks:** start is accepted in the IDLE cycle that carries the done, aborted or cfg_err pulse.
- **Arithmetic:** index arithmetic is CNT_W-bit unsigned. The legal-range check guarantees round_idx never wraps.

## Timing
- Start accepted at edge N → first round valid in cycle N+1.
- Without stalls, N rounds occupy cycles N+1 through N+rounds, and done is high in cycle N+rounds+1.
- Minimum block period is rounds+1 cycles (17 for 16 rounds).
- Each stall cycle adds exactly one cycle of latency.
- abort sampled at edge M → aborted high and busy low in cycle M+1.
- cfg_err is high in the cycle after the rejected start.
- done, aborted and cfg_err are each exactly one cycle wide and mutually exclusive.
- No combinational path from any input to any output.

## Test plan
- **16 rounds, ascending:** rounds=16, dir=0, start at edge 0.
  - round_vld high in cycles 1–16 with round_idx 0..15.
  - first in cycle 1 only; last in cycle 16 only.
  - done in cycle 17; busy low in cycle 17.
- **16 rounds, descending:** rounds=16, dir=1.
  - round_idx 15..0 in cycles 1–16, first at idx 15, last at idx 0, done in cycle 17.
  - Repeat with rounds=1: first=last=1 in cycle 1, done in cycle 2.
- **Stall:** stall high for 3 cycles while round_idx=5.
  - idx 5 held for 4 cycles total; done arrives in cycle 20.
  - A stall during the last round delays done by the same amount.
- **Abort:** abort at idx 9 with stall also high → aborted in the next cycle, done never pulses, busy=0, round_idx=0.
- **Config error and back-to-back start:**
  - start with rounds=0, then with rounds=17 → cfg_err pulses, busy stays 0.
  - start asserted in the done cycle → a new block's round 0 appears in the following cycle.
- **Reset mid-block:** rst_n low for one cycle at idx 7 → all outputs 0 in the next cycle, with no done or aborted pulse; a subsequent start runs a full block normally.
